// File: rtl/stream_capture_pkg.sv
// rtl/stream_capture_pkg.sv - shared types, constants and LFSR helpers for stream_capture
package stream_capture_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  localparam logic [15:0] LFSR_TAPS     = 16'hB400;
  localparam logic [15:0] LFSR_ZERO_SUB = 16'hACE1;
  localparam logic [7:0]  RATE_ALWAYS   = 8'hFF;

  // Right-shifting Galois form of x^16+x^14+x^13+x^11+1
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

  // An all-zero state would lock the LFSR
  function automatic logic [15:0] lfsr_seed(input logic [15:0] s);
    return (s == 16'h0000) ? LFSR_ZERO_SUB : s;
  endfunction

  function automatic logic throttle_bit(input logic [15:0] s, input logic [7:0] rate);
    return (rate == RATE_ALWAYS) || (s[7:0] < rate);
  endfunction

endpackage

// File: rtl/stream_lfsr16.sv
// rtl/stream_lfsr16.sv - 16-bit Galois LFSR with seed load and step enable
module stream_lfsr16
  import stream_capture_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        enable,
  input  logic [15:0] seed,
  output logic [15:0] state
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= LFSR_ZERO_SUB;
    end else if (load) begin
      state <= lfsr_seed(seed);
    end else if (enable) begin
      state <= lfsr_step(state);
    end
  end

endmodule

// File: rtl/stream_capture.sv
// rtl/stream_capture.sv - throttled stream sink with capture memory; optional checker via STREAM_CAPTURE_CHECK_EN
module stream_capture
  import stream_capture_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] stream_s_data_i,
  input  logic             stream_s_valid_i,
  output logic             stream_s_ready_o,
  input  logic             start_i,
  input  logic [AW:0]      length_i,
  input  logic [7:0]       rate_i,
  input  logic [15:0]      seed_i,
  input  logic [WIDTH-1:0] base_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [AW:0]      count_o,
  input  logic [AW-1:0]    rd_addr_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic [AW:0]      err_cnt_o,
  output logic [AW-1:0]    first_err_o
);

  state_t           state_q, state_d;
  logic [AW:0]      len_q, count_q, count_inc, len_clamped;
  logic [7:0]       rate_q, rate_next;
  logic             ready_q, ready_d;
  logic [15:0]      lfsr_q, lfsr_next;
  logic             start_ok, capturing, xfer;
  logic [WIDTH-1:0] rd_data_q;
  logic [WIDTH-1:0] mem [DEPTH];

  assign start_ok    = (state_q == ST_IDLE) && start_i;
  assign capturing   = (state_q == ST_CAPTURE);
  assign xfer        = capturing && stream_s_valid_i && ready_q;
  assign count_inc   = count_q + (AW+1)'(1);
  assign len_clamped = (length_i > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : length_i;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (start_i) state_d = (len_clamped == '0) ? ST_DONE : ST_CAPTURE;
      ST_CAPTURE: if (xfer && (count_inc == len_q)) state_d = ST_DONE;
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  stream_lfsr16 u_lfsr (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (start_ok),
    .enable (capturing),
    .seed   (seed_i),
    .state  (lfsr_q)
  );

  // Ready is registered from the LFSR value the next cycle will hold, so the
  // first ready after start already follows the new seed.
  assign lfsr_next = start_ok  ? lfsr_seed(seed_i) :
                     capturing ? lfsr_step(lfsr_q) : lfsr_q;
  assign rate_next = start_ok ? rate_i : rate_q;
  assign ready_d   = (state_d == ST_CAPTURE) && throttle_bit(lfsr_next, rate_next);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      count_q <= '0;
      rate_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      if (start_ok) begin
        len_q   <= len_clamped;
        rate_q  <= rate_i;
        count_q <= '0;
      end else if (xfer) begin
        count_q <= count_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (xfer) mem[count_q[AW-1:0]] <= stream_s_data_i;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) rd_data_q <= '0;
    else        rd_data_q <= mem[rd_addr_i];
  end

`ifdef STREAM_CAPTURE_CHECK_EN
  logic [WIDTH-1:0] base_q;
  logic [WIDTH-1:0] expect_word;
  logic [AW:0]      err_q;
  logic [AW-1:0]    first_q;

  assign expect_word = base_q + WIDTH'(count_q);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      base_q  <= '0;
      err_q   <= '0;
      first_q <= '0;
    end else if (start_ok) begin
      base_q  <= base_i;
      err_q   <= '0;
      first_q <= '0;
    end else if (xfer && (stream_s_data_i != expect_word)) begin
      if (err_q != '1) err_q <= err_q + (AW+1)'(1);
      if (err_q == '0) first_q <= count_q[AW-1:0];
    end
  end

  assign err_cnt_o   = err_q;
  assign first_err_o = first_q;
`else
  logic unused_base;
  assign unused_base = ^base_i;
  assign err_cnt_o   = '0;
  assign first_err_o = '0;
`endif

  assign stream_s_ready_o = ready_q;
  assign busy_o           = capturing;
  assign done_o           = (state_q == ST_DONE);
  assign count_o          = count_q;
  assign rd_data_o        = rd_data_q;

endmodule

// File: tb/tb_stream_capture.sv
// tb/tb_stream_capture.sv - scoreboard bench for stream_capture
module tb_stream_capture;

  localparam int WIDTH = 8;
  localparam int DEPTH = 1024;
  localparam int AW    = 10;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] s_data;
  logic             s_valid;
  logic             s_ready;
  logic             start;
  logic [AW:0]      length_in;
  logic [7:0]       rate_in;
  logic [15:0]      seed_in;
  logic [WIDTH-1:0] base_in;
  logic             busy;
  logic             done;
  logic [AW:0]      count;
  logic [AW-1:0]    rd_addr;
  logic [WIDTH-1:0] rd_data;
  logic [AW:0]      err_cnt;
  logic [AW-1:0]    first_err;

  stream_capture #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .stream_s_data_i  (s_data),
    .stream_s_valid_i (s_valid),
    .stream_s_ready_o (s_ready),
    .start_i          (start),
    .length_i         (length_in),
    .rate_i           (rate_in),
    .seed_i           (seed_in),
    .base_i           (base_in),
    .busy_o           (busy),
    .done_o           (done),
    .count_o          (count),
    .rd_addr_i        (rd_addr),
    .rd_data_o        (rd_data),
    .err_cnt_o        (err_cnt),
    .first_err_o      (first_err)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] sb[$];
  logic [7:0] tab[$];
  bit         rpat[$];
  bit         saved_pat[$];
  int         ones;
  int         cyc;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] model_step(input logic [15:0] s);
    logic [15:0] r;
    r = s >> 1;
    if (s[0]) r = r ^ 16'hB400;
    return r;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_block(input int length, input logic [7:0] rate, input logic [15:0] seed,
                           input logic [7:0] base, input bit rand_valid, input bit poke);
    int          eff;
    int          cnt;
    int          guard;
    logic [15:0] lf;
    bit          rdy;
    bit          v;
    logic [7:0]  w;
    eff = (length > DEPTH) ? DEPTH : length;
    sb.delete();
    rpat.delete();
    cnt = 0; guard = 0; ones = 0; cyc = 0;
    lf = (seed == 16'h0) ? 16'hACE1 : seed;
    start = 1'b1; length_in = length[AW:0]; rate_in = rate; seed_in = seed; base_in = base;
    tick;
    start = 1'b0;
    if (eff == 0) begin
      check_eq("zl_ready", s_ready, 0);
      check_eq("zl_busy", busy, 0);
      check_eq("zl_done", done, 1);
      check_eq("zl_count", count, 0);
      tick;
      check_eq("zl_done_end", done, 0);
      check_eq("zl_ready_end", s_ready, 0);
      return;
    end
    while (cnt < eff && guard < 6000) begin
      rdy = (rate == 8'hFF) || (lf[7:0] < rate);
      check_eq("ready", s_ready, rdy);
      check_eq("busy", busy, 1);
      rpat.push_back(s_ready);
      ones += int'(s_ready);
      cyc++;
      v = rand_valid ? ($urandom_range(0, 1) == 1) : 1'b1;
      w = (cnt < tab.size()) ? tab[cnt] : base + 8'(cnt);
      s_valid = v;
      s_data  = w;
      start   = poke && (guard == 2);
      if (rdy && v) begin
        sb.push_back(w);
        cnt++;
      end
      tick;
      lf = model_step(lf);
      guard++;
    end
    start = 1'b0;
    s_valid = 1'b0;
    if (cnt < eff) check_eq("timeout", cnt, eff);
    check_eq("done", done, 1);
    check_eq("ready_after_last", s_ready, 0);
    check_eq("count", count, eff);
    tick;
    check_eq("done_end", done, 0);
    check_eq("busy_end", busy, 0);
    check_eq("count_hold", count, eff);
    for (int i = 0; i < eff; i++) begin
      rd_addr = i[AW-1:0];
      tick;
      check_eq("readback", rd_data, sb.pop_front());
    end
  endtask

  initial begin
    int diffs;
    rst_n = 1'b0; s_data = '0; s_valid = 1'b0; start = 1'b0; length_in = '0;
    rate_in = '0; seed_in = '0; base_in = '0; rd_addr = '0;
    tick; tick; tick;
    check_eq("rst_ready", s_ready, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_count", count, 0);
    check_eq("rst_err", err_cnt, 0);
    check_eq("rst_first", first_err, 0);
    check_eq("rst_rd", rd_data, 0);
    rst_n = 1'b1;
    tick;

    run_block(4, 8'hFF, 16'h0001, 8'h10, 0, 0);
    check_eq("full_err", err_cnt, 0);
    run_block(0, 8'hFF, 16'h0001, 8'h00, 0, 0);

    run_block(64, 8'h80, 16'h1234, 8'h00, 0, 0);
    check_eq("duty", (ones * 4 >= cyc) && (ones * 4 <= cyc * 3), 1);
    saved_pat = rpat;
    run_block(64, 8'h80, 16'h1234, 8'h00, 0, 0);
    diffs = (saved_pat.size() == rpat.size()) ? 0 : 1000;
    for (int i = 0; i < saved_pat.size() && i < rpat.size(); i++)
      if (saved_pat[i] != rpat[i]) diffs++;
    check_eq("repeat_pattern", diffs, 0);

    run_block(32, 8'hC0, 16'h0000, 8'h55, 1, 0);

    start = 1'b1; length_in = 11'd4; rate_in = 8'h00; seed_in = 16'h0BAD;
    tick;
    start = 1'b0; s_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      check_eq("rate0_ready", s_ready, 0);
      check_eq("rate0_busy", busy, 1);
      tick;
    end
    s_valid = 1'b0; rst_n = 1'b0;
    tick;
    rst_n = 1'b1;

    start = 1'b1; length_in = 11'd16; rate_in = 8'hFF; seed_in = 16'h0001;
    tick;
    start = 1'b0; s_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      s_data = 8'h40 + 8'(k);
      tick;
    end
    check_eq("mid_count", count, 5);
    rst_n = 1'b0; s_valid = 1'b0;
    tick;
    check_eq("mid_rst_ready", s_ready, 0);
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_count", count, 0);
    check_eq("mid_rst_done", done, 0);
    check_eq("mid_rst_err", err_cnt, 0);
    rst_n = 1'b1;
    rd_addr = 10'd3;
    tick;
    check_eq("mem_kept", rd_data, 8'h43);
    run_block(4, 8'hFF, 16'h0001, 8'h70, 0, 0);

    run_block(8, 8'hFF, 16'h0001, 8'h30, 0, 1);
    run_block(DEPTH + 1, 8'hFF, 16'h0001, 8'h00, 0, 0);

    tab = '{8'h20, 8'h21, 8'h99, 8'h23, 8'h77};
    run_block(5, 8'hFF, 16'h0001, 8'h20, 0, 0);
    tab.delete();
`ifdef STREAM_CAPTURE_CHECK_EN
    check_eq("err_cnt", err_cnt, 2);
    check_eq("first_err", first_err, 2);
`else
    check_eq("err_cnt_tied", err_cnt, 0);
    check_eq("first_err_tied", first_err, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/stream_capture.md
# stream_capture

Synthesizable stream sink that terminates a valid/ready stream on the slave side. On `start_i` it accepts a block of up to `DEPTH` words into an internal capture memory. It throttles `stream_s_ready_o` with an LFSR-driven, programmable acceptance rate so upstream stallers are exercised. It is the receiving end of the team's stream master models and DUT outputs, and captured words are read back through a synchronous read port.

## Interface
- `WIDTH`, 8: data word width.
- `DEPTH`, 1024: maximum block length in words (power of two).
- `AW`, $clog2(DEPTH): capture address width.
- `clk` in 1: single clock, all logic on rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `stream_s_data_i` in WIDTH: stream data.
- `stream_s_valid_i` in 1: stream valid.
- `stream_s_ready_o` out 1: stream ready, registered.
- `start_i` in 1: begin capture; honoured only in IDLE.
- `length_i` in AW+1: words to capture, sampled at start.
- `rate_i` in 8: acceptance rate, sampled at start.
- `seed_i` in 16: LFSR seed, sampled at start.
- `base_i` in WIDTH: first expected word (check feature), sampled at start.
- `busy_o` out 1: high in CAPTURE.
- `done_o` out 1: one-cycle pulse on block completion.
- `count_o` out AW+1: words accepted in the current or last block.
- `rd_addr_i` in AW: capture memory read address.
- `rd_data_o` out WIDTH: read data, one-cycle latency.
- `err_cnt_o` out AW+1: mismatch count (check feature).
- `first_err_o` out AW: index of the first mismatch (check feature).

## Operation
- The FSM has three states: IDLE, CAPTURE and DONE. Reset enters IDLE.
- **IDLE**, on `start_i`:
  - Latch `len = min(length_i, DEPTH)`, `rate_i`, `base_i`.
  - Load the LFSR with `seed_i`; a seed of 0 is replaced by 16'hACE1.
  - Clear `count_o` and the error state.
  - Go to CAPTURE, or go to DONE directly if `len == 0`.
- **CAPTURE**:
  - A transfer occurs at an edge where `valid && ready`.
  - The word is written to `mem[count]` and `count` increments.
  - When the accepted word makes `count == len`, the next state is DONE.
- **DONE**: lasts exactly one cycle with `done_o = 1`, then returns to IDLE.
- **LFSR**:
  - 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1.
  - Steps every cycle in CAPTURE and holds otherwise.
  - Throttle bit is `(rate == 8'hFF) || (lfsr[7:0] < rate)`.
  - `rate == 0` means ready never rises; the block stays busy until reset.
- **Ready**: the register's next value is `(next_state == CAPTURE) && throttle_bit`. Ready is therefore 0 on the cycle after the last word, and is 0 in IDLE and DONE.
- **Start while busy**: `start_i` in CAPTURE or DONE is ignored.
- **Count**: `count_o` holds its value after DONE until the next start.
- **Reset mid-operation**:
  - Returns to IDLE with ready 0, `count_o` 0, `done_o` 0, error outputs 0.
  - Memory contents are not cleared.

## Timing
- **Reset values**: `stream_s_ready_o`, `busy_o`, `done_o`, `count_o`, `err_cnt_o` and `first_err_o` are 0; `rd_data_o` is 0.
- **Start to ready**: start sampled at edge N means `busy_o` and (throttle permitting) ready are high from N+1.
- **Completion**: last transfer at edge M means `done_o` is high in cycle M+1 to M+2, and the block is back in IDLE from M+2.
- **Upstream ready independence**: ready may drop without a transfer (legal for a slave); it never depends combinationally on `stream_s_valid_i`.
- **Read port**: `rd_data_o` is registered from `mem[rd_addr_i]`, valid the cycle after the address, in any state. On a read and write to the same address in one cycle, the read returns the old data.
- **Throughput**: one word per cycle at `rate == 8'hFF` with valid held high.

## Configuration
- Macro: `STREAM_CAPTURE_CHECK_EN`.
- **Defined**: each accepted word at index i is compared with `(base + i) mod 2^WIDTH`.
  - Each mismatch increments `err_cnt_o`, saturating at all-ones.
  - The first mismatch sets `first_err_o = i`.
- **Undefined**: no comparator logic; `err_cnt_o` and `first_err_o` are tied to 0. Ports are present in both builds.

## Structure
- Package `stream_capture_pkg` holds:
  - The state enum (IDLE, CAPTURE, DONE).
  - LFSR polynomial tap constant 16'hB400.
  - Zero-seed substitute 16'hACE1.
  - Rate constant `RATE_ALWAYS = 8'hFF`.
- Sub-module `stream_lfsr16` (load/enable/state out) is natural and reusable by future stream master models. The memory is inferred inline.

## Test plan
- **Full rate**: `length_i = 4`, `rate_i = 8'hFF`, valid held with data 10,11,12,13 → ready high 4 cycles, `done_o` pulse, `count_o = 4`, readback `mem[0..3] = 10..13`.
- **Zero length**: `length_i = 0`, `start_i` → ready never rises, `done_o` pulses at start+1, `count_o = 0`.
- **Throttled rate**: `rate_i = 8'h80`, seed 16'h1234, `length_i = 64` → every word captured in order, ready duty roughly 50%, no transfer when ready is low. Repeating with the same seed gives an identical ready pattern.
- **Reset mid-block**: `rst_n` low after 5 of 16 words → next cycle ready 0, `busy_o` 0, `count_o` 0. A subsequent start works normally.
- **Ignored start and clamping**: `start_i` asserted during CAPTURE → ignored. `length_i = DEPTH + 1` → clamps to DEPTH.
- **Check feature** (`STREAM_CAPTURE_CHECK_EN` defined): `base_i = 8'h20`, stream 20,21,99,23,77 → `err_cnt_o = 2`, `first_err_o = 2`.
